// File: rtl/i2s_frame_sequencer.sv
// i2s_frame_sequencer: master I2S frame generator for the AD1868 bridge.
// Runs in the I2S master-clock domain only. It derives BCLK/LRCK from a
// divider and a bit counter, requests new samples through a latch window,
// shifts 18-bit samples out MSB-first with the one-BCLK I2S delay, and
// auto-mutes whenever the AD-side latch pulse is not seen every frame.
//
// Every registered output is computed from the next-state counter values,
// so in any cycle the outputs correspond to the counter values held in that
// same cycle (no extra pipeline offset between counters and pins).
module i2s_frame_sequencer #(
  parameter int BCLK_DIV    = 4,
  parameter int SLOT_BITS   = 64,
  parameter int DATA_BITS   = 18,
  parameter int LATCH_BITS  = 16,
  parameter int LOCK_FRAMES = 4
) (
  input  logic                 i_i2s_mclk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_data_l,
  input  logic [DATA_BITS-1:0] i_data_r,
  input  logic                 i_ad_latch_pulse,
  input  logic                 i_mute,
  output logic                 o_i2s_bclk,
  output logic                 o_i2s_lrck,
  output logic                 o_i2s_sdata,
  output logic                 o_i2s_latch,
  output logic                 o_frame_start,
  output logic                 o_locked
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int IDX_W      = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam int CNT_W      = $clog2(LOCK_FRAMES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT      = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] GOOD_MAX  = CNT_W'(LOCK_FRAMES);

  // ---------------------------------------------------------------------
  // Frame counters. running_q is low only in the cycles spent in reset;
  // it forces the first cycle after release to be a frame start instead of
  // div=1.
  // ---------------------------------------------------------------------
  logic             running_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             frame_start_d;

  // Lock monitor state.
  logic             sync1_q, sync2_q, ad_prev_q;
  logic             ad_edge;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic             locked_q, locked_d;

  // Per-frame captured data and mute decision.
  logic                 mute_q, mute_d;
  logic [DATA_BITS-1:0] shadow_l_q, shadow_l_d;
  logic [DATA_BITS-1:0] shadow_r_q, shadow_r_d;

  // Next-state output values.
  logic                 bclk_d, lrck_d, latch_d, sdata_d;
  logic [BIT_W-1:0]     pos_d;
  logic                 data_on;
  logic [IDX_W-1:0]     idx_d;
  logic [DATA_BITS-1:0] sample_d;

  // Rising edge of the synchronised AD latch pulse.
  assign ad_edge  = sync2_q & ~ad_prev_q;
  assign o_locked = locked_q;

  // Next-state divider and bit counter; the bit counter advances on divider wrap.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    div_d = div_q;
    bit_d = bit_q;
    if (!running_q) begin
      div_d = '0;
      bit_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  assign frame_start_d = (div_d == '0) && (bit_d == '0);

  // Next-state clocks, latch window and serial data bit from the next counters.
  always_comb begin
    bclk_d   = (div_d >= DIV_HALF);
    lrck_d   = (int'(bit_d) >= SLOT_BITS);
    latch_d  = (int'(bit_d) >= SLOT_BITS) && (int'(bit_d) < SLOT_BITS + LATCH_BITS);
    pos_d    = lrck_d ? (bit_d - SLOT) : bit_d;
    data_on  = (pos_d != '0) && (int'(pos_d) <= DATA_BITS);
    idx_d    = IDX_W'(DATA_LAST - pos_d);
    sample_d = lrck_d ? shadow_r_q : shadow_l_q;
    sdata_d  = 1'b0;
    // Slot position 0 is the I2S delay bit; the frame-start cycle always
    // lands there, so the mute flag held from the previous frame is never
    // used for a data bit of the new frame.
    if (data_on && !mute_q) begin
      sdata_d = sample_d[idx_d];
    end
  end

  // Frame-start bookkeeping: evaluate lock, decide mute, capture samples.
  always_comb begin
    good_d     = good_q;
    locked_d   = locked_q;
    seen_d     = seen_q | ad_edge;
    mute_d     = mute_q;
    shadow_l_d = shadow_l_q;
    shadow_r_d = shadow_r_q;
    if (frame_start_d) begin
      if (seen_q) begin
        good_d   = (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;
        locked_d = (good_d == GOOD_MAX);
      end else begin
        good_d   = '0;
        locked_d = 1'b0;
      end
      // A frame plays only if lock held going in and survives this
      // evaluation: rising lock waits one frame, losing lock mutes at once.
      mute_d     = i_mute | ~locked_q | ~locked_d;
      shadow_l_d = i_data_l;
      shadow_r_d = i_data_r;
      // An edge arriving on the frame-start cycle belongs to the new frame.
      seen_d     = ad_edge;
    end
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge i_i2s_mclk) begin
    // NOTE: reset is sampled on the clock edge only; i_rst_n is not in the
    // sensitivity list, so a reset pulse must span a rising edge.
    if (!i_rst_n) begin
      running_q     <= 1'b0;
      div_q         <= '0;
      bit_q         <= '0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      ad_prev_q     <= 1'b0;
      seen_q        <= 1'b0;
      good_q        <= '0;
      locked_q      <= 1'b0;
      mute_q        <= 1'b0;
      shadow_l_q    <= '0;
      shadow_r_q    <= '0;
      o_i2s_bclk    <= 1'b0;
      o_i2s_lrck    <= 1'b0;
      o_i2s_sdata   <= 1'b0;
      o_i2s_latch   <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      running_q     <= 1'b1;
      div_q         <= div_d;
      bit_q         <= bit_d;
      sync1_q       <= i_ad_latch_pulse;
      sync2_q       <= sync1_q;
      ad_prev_q     <= sync2_q;
      seen_q        <= seen_d;
      good_q        <= good_d;
      locked_q      <= locked_d;
      mute_q        <= mute_d;
      shadow_l_q    <= shadow_l_d;
      shadow_r_q    <= shadow_r_d;
      o_i2s_bclk    <= bclk_d;
      o_i2s_lrck    <= lrck_d;
      o_i2s_sdata   <= sdata_d;
      o_i2s_latch   <= latch_d;
      o_frame_start <= frame_start_d;
    end
  end

endmodule

// File: doc/i2s_frame_sequencer.md
# i2s_frame_sequencer

Master I2S frame generator and output scheduler for the AD1868 bridge, running entirely in the 24.576 MHz I2S master-clock domain. It derives BCLK and LRCK, requests fresh 18-bit left/right samples from the sample latches via a wide latch window, and shifts them out MSB-first in standard I2S format. It also watches the AD-side latch pulse to decide whether the upstream source is locked, and auto-mutes the output when it is not.

## Interface
- BCLK_DIV, 4: mclk cycles per BCLK period; even, ≥2.
- SLOT_BITS, 64: BCLK periods per channel slot; frame length is 2*SLOT_BITS.
- DATA_BITS, 18: sample width; must be < SLOT_BITS.
- LATCH_BITS, 16: length of the o_i2s_latch window, in BCLK periods.
- LOCK_FRAMES, 4: consecutive frames with an AD latch edge required to assert lock.
- i_i2s_mclk  in  1  24.576 MHz master clock; the only clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_data_l  in  18  left sample from the left SampleLatch; stable while o_i2s_latch is low.
- i_data_r  in  18  right sample from the right SampleLatch; same rule.
- i_ad_latch_pulse  in  1  AD-side latch pulse, asynchronous to i_i2s_mclk.
- i_mute  in  1  force zero output data; sampled at frame start.
- o_i2s_bclk  out  1  bit clock.
- o_i2s_lrck  out  1  word clock; 0 = left, 1 = right.
- o_i2s_sdata  out  1  serial data.
- o_i2s_latch  out  1  latch-request window to the SampleLatches.
- o_frame_start  out  1  one-mclk pulse on the first cycle of each frame.
- o_locked  out  1  upstream lock status.

## Operation
- Counters:
  - div runs 0..BCLK_DIV-1 and wraps.
  - bit runs 0..2*SLOT_BITS-1; it increments when div wraps, and wraps itself at the frame end.
- Registered outputs are derived from the next-state counter values, so each output lines up with the counters below:
  - o_i2s_bclk = (div ≥ BCLK_DIV/2).
  - o_i2s_lrck = (bit ≥ SLOT_BITS).
- Frame start is the cycle where div==0 and bit==0:
  - o_frame_start=1.
  - Shadow registers capture i_data_l and i_data_r.
  - The mute flag captures i_mute OR !o_locked.
- Serial data, with slot position p = bit mod SLOT_BITS and ch = lrck:
  - o_i2s_sdata = shadow_ch[DATA_BITS-p] for 1 ≤ p ≤ DATA_BITS.
  - Otherwise, or when the mute flag is set, o_i2s_sdata = 0.
  - This gives the standard one-BCLK I2S delay, MSB first.
  - sdata changes only in div==0 cycles, i.e. on BCLK falling edges.
- o_i2s_latch is 1 while SLOT_BITS ≤ bit < SLOT_BITS+LATCH_BITS. This is a 64-mclk window (≥ 4 AD sync-clock periods), ending well before the next frame-start capture.
- Lock monitor:
  - i_ad_latch_pulse passes through a 2-FF synchronizer, then a rising-edge detector.
  - A per-frame "seen" flag is set by a detected edge and cleared at each frame start, after being evaluated.
  - At frame start, a frame that saw an edge increments good_cnt (saturating at LOCK_FRAMES). A frame that did not clears good_cnt and o_locked.
  - o_locked goes to 1 when good_cnt reaches LOCK_FRAMES.
  - An edge detected in the same cycle as frame start counts toward the new frame.

## Timing
- Reset (i_rst_n=0 on a clock edge) clears everything on that edge:
  - div=0, bit=0, shadows=0, good_cnt=0, seen=0, synchronizer=0.
  - Outputs: o_i2s_bclk=0, o_i2s_lrck=0, o_i2s_sdata=0, o_i2s_latch=0, o_frame_start=0, o_locked=0.
- Reset mid-frame aborts the frame immediately. The first cycle after release is a frame start (div=0, bit=0, o_frame_start=1), with the mute flag set because o_locked=0.
- Defaults: BCLK 6.144 MHz, frame 512 mclk, fs 48 kHz. The LRCK edge occurs at BCLK falling edges only.
- Data latency:
  - Sample captured at frame start N: the left MSB appears at mclk cycle 4 (bit 1), the right MSB at cycle 260 (bit 65).
  - Input data captured at frame start N is played during frame N.
- i_mute or lock loss changes the output only at the next frame start; no partial-frame mute.
- AD edge-to-"seen" latency is 3 mclk; edges closer than 2 mclk apart are not resolved (AD pulses are ≥16 mclk).

## Test plan
- Reset release, free-run 3 frames:
  - BCLK period 4 mclk.
  - LRCK toggles every 256 mclk; first rise at cycle 256.
  - o_frame_start at cycles 0, 512, 1024.
  - o_i2s_latch high for cycles 256..319 of each frame.
- i_data_l=18'h2AAAA, i_data_r=18'h15555, AD pulse every 512 mclk, i_mute=0:
  - o_locked rises at the 4th frame start.
  - From the next frame, left slot bits 1..18 = 101010…10, right slot bits 65..82 = 010101…01.
  - All other bits are 0.
- Locked, then AD pulses stop: o_locked falls at the first frame start after a pulse-free frame, and that frame's sdata is all 0.
- Locked, raise i_mute at mclk 100 of a frame: that frame still carries data; the next frame is all zeros; dropping i_mute restores data one frame later.
- Change i_data_l at mclk 300 (inside the latch window): the frame in progress is unaffected; the new value appears in the next frame's left slot.
- Assert i_rst_n=0 for 1 cycle at mclk 200: all outputs are 0 the next cycle; the frame restarts with o_frame_start=1; o_locked requires 4 fresh frames.
